ddr_rw_arbiter: RTL and testbench

DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

---
 rtl/ddr_rw_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_arbiter.sv
// DDR read/write burst arbiter.
// Moves fixed-length bursts between a write FIFO, a DDR command/data
// interface and a read FIFO. Write and read offsets walk their frame
// regions and are rewound by the frame-sync pulses from the video side.
module ddr_rw_arbiter #(
   parameter int BURST_LEN   = 64,
   parameter int FRAME_BEATS = 98304,
   parameter int WR_BASE     = 0,
   parameter int RD_BASE     = 0,
   parameter int RFIFO_LOW   = 512
) (
   input  logic         clk_100,
   input  logic         rst_n,
   input  logic         ddr_init_done,
   input  logic         wr_load,
   input  logic         rd_load,
   input  logic [10:0]  wfifo_rcount,
   input  logic [127:0] wfifo_rd_data,
   output logic         wfifo_rd_en,
   input  logic [10:0]  rfifo_wcount,
   output logic         rfifo_wr_en,
   output logic [127:0] rfifo_wr_data,
   output logic         cmd_valid,
   input  logic         cmd_ready,
   output logic         cmd_wr,
   output logic [27:0]  cmd_addr,
   output logic [7:0]   cmd_len,
   output logic         wdata_valid,
   input  logic         wdata_ready,
   output logic [127:0] wdata,
   input  logic         rdata_valid,
   input  logic [127:0] rdata
);

   localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
   localparam logic [28:0] STEP      = 29'(BURST_LEN);
   localparam logic [28:0] FRAME_END = 29'(FRAME_BEATS);
   localparam logic [11:0] WR_THRESH = 12'(BURST_LEN);
   localparam logic [11:0] RD_THRESH = 12'(RFIFO_LOW);
   localparam logic [27:0] WR_BASE_A = 28'(WR_BASE);
   localparam logic [27:0] RD_BASE_A = 28'(RD_BASE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_CMD,
      S_WR_DATA,
      S_RD_CMD,
      S_RD_DATA
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [27:0] r_wr_off;
   logic [27:0] r_rd_off;
   logic [7:0]  r_beat_cnt;
   logic        r_last_wr;      // 1: last served burst was a write, 0: a read

   logic        w_in_idle;
   logic        w_wr_req;
   logic        w_rd_req;
   logic        w_last_beat;
   logic        w_wr_beat;
   logic        w_rd_beat;
   logic        w_cmd_fire;
   logic [28:0] w_wr_sum;
   logic [28:0] w_rd_sum;
   logic [27:0] w_wr_off_adv;
   logic [27:0] w_rd_off_adv;

   // index 0 = write-side frame sync, index 1 = read-side frame sync
   logic [1:0]  w_load_in;
   logic [1:0]  w_edge;
   logic [1:0]  w_pend;

   assign w_load_in   = {rd_load, wr_load};
   assign w_in_idle   = (r_state == S_IDLE);
   assign w_wr_req    = ({1'b0, wfifo_rcount} >= WR_THRESH);
   assign w_rd_req    = ({1'b0, rfifo_wcount} <  RD_THRESH);
   assign w_last_beat = (r_beat_cnt == LAST_BEAT);
   assign w_cmd_fire  = cmd_valid & cmd_ready;

   // offset advance, wrapping to the start of the region at the frame end
   assign w_wr_sum     = {1'b0, r_wr_off} + STEP;
   assign w_rd_sum     = {1'b0, r_rd_off} + STEP;
   assign w_wr_off_adv = (w_wr_sum >= FRAME_END) ? 28'd0 : w_wr_sum[27:0];
   assign w_rd_off_adv = (w_rd_sum >= FRAME_END) ? 28'd0 : w_rd_sum[27:0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic [2:0] r_sync;
         logic       r_pend;

         // two synchronizer flops plus one history flop for edge detection
         always_ff @(posedge clk_100 or negedge rst_n) begin
            if (!rst_n) r_sync <= 3'b000;
            else        r_sync <= {r_sync[1:0], w_load_in[gi]};
         end

         assign w_edge[gi] = r_sync[1] & ~r_sync[2];

         // sticky request, consumed in IDLE; a new edge that cycle keeps it set
         always_ff @(posedge clk_100 or negedge rst_n) begin
            if (!rst_n) r_pend <= 1'b0;
            else        r_pend <= w_edge[gi] | (r_pend & ~w_in_idle);
         end

         assign w_pend[gi] = r_pend;
      end
   endgenerate

   // state register
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // next-state decode and all channel outputs
   always_comb begin
      w_state_next  = r_state;
      cmd_valid     = 1'b0;
      cmd_wr        = 1'b0;
      cmd_addr      = 28'd0;
      cmd_len       = 8'd0;
      wdata_valid   = 1'b0;
      wdata         = 128'd0;
      wfifo_rd_en   = 1'b0;
      rfifo_wr_en   = 1'b0;
      rfifo_wr_data = 128'd0;
      w_wr_beat     = 1'b0;
      w_rd_beat     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ddr_init_done) begin
               if (w_wr_req && w_rd_req) w_state_next = r_last_wr ? S_RD_CMD : S_WR_CMD;
               else if (w_wr_req)        w_state_next = S_WR_CMD;
               else if (w_rd_req)        w_state_next = S_RD_CMD;
            end
         end
         S_WR_CMD: begin
            cmd_valid = 1'b1;
            cmd_wr    = 1'b1;
            cmd_addr  = WR_BASE_A + r_wr_off;
            cmd_len   = LAST_BEAT;
            if (cmd_ready) w_state_next = S_WR_DATA;
         end
         S_WR_DATA: begin
            wdata_valid = 1'b1;
            wdata       = wfifo_rd_data;
            wfifo_rd_en = wdata_ready;
            w_wr_beat   = wdata_ready;
            if (wdata_ready && w_last_beat) w_state_next = S_IDLE;
         end
         S_RD_CMD: begin
            cmd_valid = 1'b1;
            cmd_wr    = 1'b0;
            cmd_addr  = RD_BASE_A + r_rd_off;
            cmd_len   = LAST_BEAT;
            if (cmd_ready) w_state_next = S_RD_DATA;
         end
         S_RD_DATA: begin
            rfifo_wr_en   = rdata_valid;
            rfifo_wr_data = rdata;
            w_rd_beat     = rdata_valid;
            if (rdata_valid && w_last_beat) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // beat counter and round-robin history
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt <= 8'd0;
         r_last_wr  <= 1'b0;
      end else begin
         if (w_cmd_fire)                     r_beat_cnt <= 8'd0;
         else if (w_wr_beat || w_rd_beat)    r_beat_cnt <= r_beat_cnt + 8'd1;
         if (w_wr_beat && w_last_beat)       r_last_wr  <= 1'b1;
         else if (w_rd_beat && w_last_beat)  r_last_wr  <= 1'b0;
      end
   end

   // frame offsets: a pending sync rewinds in IDLE, after any burst advance
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_off <= 28'd0;
         r_rd_off <= 28'd0;
      end else begin
         if (w_in_idle && w_pend[0])          r_wr_off <= 28'd0;
         else if (w_wr_beat && w_last_beat)   r_wr_off <= w_wr_off_adv;
         if (w_in_idle && w_pend[1])          r_rd_off <= 28'd0;
         else if (w_rd_beat && w_last_beat)   r_rd_off <= w_rd_off_adv;
      end
   end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Directed bench for ddr_rw_arbiter with FIFO and DDR behavioural models.
module tb_ddr_rw_arbiter;

   localparam int BL   = 64;
   localparam int FB   = 192;
   localparam logic [27:0] WB = 28'h100;
   localparam logic [27:0] RB = 28'h4000;

   logic         clk_100 = 1'b0;
   logic         rst_n = 1'b0;
   logic         ddr_init_done = 1'b0;
   logic         wr_load = 1'b0;
   logic         rd_load = 1'b0;
   logic [10:0]  wfifo_rcount = 11'd0;
   logic [127:0] wfifo_rd_data = 128'd0;
   logic         wfifo_rd_en;
   logic [10:0]  rfifo_wcount = 11'd600;
   logic         rfifo_wr_en;
   logic [127:0] rfifo_wr_data;
   logic         cmd_valid;
   logic         cmd_ready = 1'b1;
   logic         cmd_wr;
   logic [27:0]  cmd_addr;
   logic [7:0]   cmd_len;
   logic         wdata_valid;
   logic         wdata_ready = 1'b1;
   logic [127:0] wdata;
   logic         rdata_valid = 1'b0;
   logic [127:0] rdata = 128'd0;

   ddr_rw_arbiter #(
      .BURST_LEN(BL), .FRAME_BEATS(FB), .WR_BASE(int'(WB)),
      .RD_BASE(int'(RB)), .RFIFO_LOW(512)
   ) dut (
      .clk_100(clk_100), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
      .wr_load(wr_load), .rd_load(rd_load),
      .wfifo_rcount(wfifo_rcount), .wfifo_rd_data(wfifo_rd_data), .wfifo_rd_en(wfifo_rd_en),
      .rfifo_wcount(rfifo_wcount), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata)
   );

   always #5 clk_100 = ~clk_100;

   typedef struct packed {
      logic        wr;
      logic [27:0] addr;
      logic [7:0]  len;
   } cmd_t;

   cmd_t        log_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_cv = 0;          // cycles with cmd_valid high
   int          n_wpop = 0;
   int          n_rpush = 0;
   int          n_badpop = 0;      // pops without wdata handshake
   int          n_baddata = 0;
   int          wf_cnt = 0;
   int          rf_cnt = 600;
   int          owed = 0;          // read beats the DDR model still has to return
   logic        rv_real = 1'b0;
   logic [31:0] wf_data = 32'd0;
   logic [31:0] rd_data = 32'd0;
   int          wr_pulse = 0;
   int          rd_pulse = 0;
   int          load_target = -1;
   logic        toggle_wr = 1'b0;
   logic        spur = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic check_cmd(input string tag, input int idx, input logic wr, input logic [27:0] addr);
      if (idx < log_q.size()) begin
         check($sformatf("%s_wr", tag), 64'(log_q[idx].wr), 64'(wr));
         check($sformatf("%s_addr", tag), 64'(log_q[idx].addr), 64'(addr));
         check($sformatf("%s_len", tag), 64'(log_q[idx].len), 64'(BL - 1));
      end else begin
         check($sformatf("%s_present", tag), 64'(log_q.size()), 64'(idx + 1));
      end
   endtask

   // one clock: observe at negedge, then update models and drive after posedge
   task automatic tick();
      @(negedge clk_100);
      if (cmd_valid) n_cv++;
      if (rdata_valid && rv_real) owed--;
      if (cmd_valid && cmd_ready) begin
         log_q.push_back('{cmd_wr, cmd_addr, cmd_len});
         if (!cmd_wr) owed += BL;
      end
      if (wfifo_rd_en) begin
         n_wpop++;
         if (!wdata_ready || !wdata_valid) n_badpop++;
         if (wdata !== {4{wf_data}}) n_baddata++;
         wf_data++;
         if (wf_cnt > 0) wf_cnt--;
         if (n_wpop == load_target) wr_pulse = 4;
      end
      if (rfifo_wr_en) begin
         n_rpush++;
         if (rfifo_wr_data !== rdata) n_baddata++;
         rf_cnt++;
      end
      @(posedge clk_100);
      #1;
      wfifo_rcount  = 11'(wf_cnt);
      wfifo_rd_data = {4{wf_data}};
      rfifo_wcount  = 11'(rf_cnt);
      wdata_ready   = toggle_wr ? ~wdata_ready : 1'b1;
      wr_load       = (wr_pulse > 0);
      rd_load       = (rd_pulse > 0);
      if (wr_pulse > 0) wr_pulse--;
      if (rd_pulse > 0) rd_pulse--;
      rv_real = (owed > 0);
      if (rv_real) begin
         rd_data++;
         rdata_valid = 1'b1;
      end else begin
         rdata_valid = spur;
      end
      rdata = {4{rd_data}};
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int p0;
   int r0;
   int guard;

   initial begin
      // reset values
      run(3);
      #1;
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      check("rst_cmd_len", 64'(cmd_len), 64'd0);
      check("rst_wdata_valid", 64'(wdata_valid), 64'd0);
      check("rst_wfifo_rd_en", 64'(wfifo_rd_en), 64'd0);
      check("rst_rfifo_wr_en", 64'(rfifo_wr_en), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      rst_n = 1'b1;

      // no activity before calibration
      wf_cnt = 100;
      run(1000);
      check("init_hold_cmd_cycles", 64'(n_cv), 64'd0);
      wf_cnt = 0;
      run(2);
      ddr_init_done = 1'b1;
      run(2);

      // single write burst
      log_q.delete();
      p0 = n_wpop;
      wf_cnt = 64;
      run(100);
      check("single_cmd_count", 64'(log_q.size()), 64'd1);
      check_cmd("single_cmd", 0, 1'b1, WB);
      check("single_pops", 64'(n_wpop - p0), 64'd64);
      check("single_idle", 64'({cmd_valid, wdata_valid}), 64'd0);

      // reset mid-burst aborts at once
      log_q.delete();
      p0 = n_wpop;
      wf_cnt = 64;
      guard = 0;
      while (n_wpop < p0 + 10 && guard < 200) begin
         tick();
         guard++;
      end
      check("midrst_reached_beat10", 64'(n_wpop - p0), 64'd10);
      check_cmd("midrst_cmd", 0, 1'b1, WB + 28'd64);
      rst_n = 1'b0;
      #1;
      check("midrst_wdata_valid", 64'(wdata_valid), 64'd0);
      check("midrst_wfifo_rd_en", 64'(wfifo_rd_en), 64'd0);
      run(3);
      check("midrst_no_more_pops", 64'(n_wpop - p0), 64'd10);
      rst_n = 1'b1;
      run(2);

      // round robin with both requests true, write first after reset
      log_q.delete();
      p0 = n_wpop;
      r0 = n_rpush;
      wf_cnt = 128;
      rf_cnt = 384;
      run(400);
      check("rr_cmd_count", 64'(log_q.size()), 64'd4);
      check_cmd("rr_w0", 0, 1'b1, WB);
      check_cmd("rr_r0", 1, 1'b0, RB);
      check_cmd("rr_w1", 2, 1'b1, WB + 28'd64);
      check_cmd("rr_r1", 3, 1'b0, RB + 28'd64);
      check("rr_pops", 64'(n_wpop - p0), 64'd128);
      check("rr_pushes", 64'(n_rpush - r0), 64'd128);

      // write offset wrap at the frame end (offset starts at 128)
      log_q.delete();
      wf_cnt = 256;
      run(350);
      check("wrap_cmd_count", 64'(log_q.size()), 64'd4);
      check_cmd("wrap_0", 0, 1'b1, WB + 28'd128);
      check_cmd("wrap_1", 1, 1'b1, WB);
      check_cmd("wrap_2", 2, 1'b1, WB + 28'd64);
      check_cmd("wrap_3", 3, 1'b1, WB + 28'd128);

      // write frame sync during the 10th beat of the burst at offset 64
      log_q.delete();
      p0 = n_wpop;
      load_target = n_wpop + 64 + 9;
      wf_cnt = 192;
      run(300);
      load_target = -1;
      check("wsync_cmd_count", 64'(log_q.size()), 64'd3);
      check_cmd("wsync_0", 0, 1'b1, WB);
      check_cmd("wsync_1", 1, 1'b1, WB + 28'd64);
      check_cmd("wsync_2", 2, 1'b1, WB);
      check("wsync_pops", 64'(n_wpop - p0), 64'd192);

      // read frame sync while idle, then a stalled read command
      rd_pulse = 4;
      run(12);
      log_q.delete();
      r0 = n_rpush;
      cmd_ready = 1'b0;
      rf_cnt = 448;
      run(10);
      check("rstall_cmd_valid", 64'(cmd_valid), 64'd1);
      check("rstall_cmd_wr", 64'(cmd_wr), 64'd0);
      check("rstall_cmd_addr", 64'(cmd_addr), 64'(RB));
      check("rstall_no_handshake", 64'(log_q.size()), 64'd0);
      cmd_ready = 1'b1;
      run(100);
      check("rsync_cmd_count", 64'(log_q.size()), 64'd1);
      check_cmd("rsync_0", 0, 1'b0, RB);
      check("rsync_pushes", 64'(n_rpush - r0), 64'd64);

      // wdata_ready toggling, rdata_valid asserted outside any read burst
      log_q.delete();
      p0 = n_wpop;
      r0 = n_rpush;
      toggle_wr = 1'b1;
      spur = 1'b1;
      wf_cnt = 64;
      run(200);
      toggle_wr = 1'b0;
      spur = 1'b0;
      run(2);
      check("toggle_cmd_count", 64'(log_q.size()), 64'd1);
      check_cmd("toggle_0", 0, 1'b1, WB + 28'd64);
      check("toggle_pops", 64'(n_wpop - p0), 64'd64);
      check("spur_no_rfifo_write", 64'(n_rpush - r0), 64'd0);
      check("toggle_idle", 64'({cmd_valid, wdata_valid}), 64'd0);

      check("pop_without_handshake", 64'(n_badpop), 64'd0);
      check("data_passthrough", 64'(n_baddata), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
